// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, one clock.
// Define RAM_WRITE_THROUGH_EN for write-first same-address behaviour; read-first otherwise.
module dual_port_ram #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               write_enable,
    input  logic [A_WIDTH-1:0] address_write,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic [A_WIDTH-1:0] address_read,
    output logic [D_WIDTH-1:0] data_read
);

    // One extra bit so A_MAX == 2**A_WIDTH is representable as the exclusive limit.
    localparam logic [A_WIDTH:0] A_LIMIT = (A_WIDTH + 1)'(A_MAX);

    logic [D_WIDTH-1:0] mem_q [A_MAX];
    logic [D_WIDTH-1:0] mem_d [A_MAX];
    logic [D_WIDTH-1:0] data_read_q;
    logic [D_WIDTH-1:0] data_read_d;
    logic               wr_hit;
    logic               rd_hit;

    assign wr_hit = write_enable && ({1'b0, address_write} < A_LIMIT);
    assign rd_hit = ({1'b0, address_read} < A_LIMIT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mem_d       = mem_q;
        data_read_d = '0;
        if (wr_hit) begin
            mem_d[address_write] = data_write;
        end
        if (rd_hit) begin
`ifdef RAM_WRITE_THROUGH_EN
            data_read_d = mem_d[address_read];
`else
            data_read_d = mem_q[address_read];
`endif
        end
    end

    // NOTE: the array is deliberately reset, so it maps to flops rather than a block RAM;
    // non-blocking assignments keep every flop updated from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < A_MAX; i++) begin
                mem_q[i] <= '0;
            end
            data_read_q <= '0;
        end else begin
            mem_q       <= mem_d;
            data_read_q <= data_read_d;
        end
    end

    assign data_read = data_read_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram; a second instance with A_MAX=20
// shares all inputs to exercise the out-of-range address behaviour.
module tb_dual_port_ram;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write_enable;
    logic [AW-1:0] address_write;
    logic [DW-1:0] data_write;
    logic [AW-1:0] address_read;
    logic [DW-1:0] data_read;
    logic [DW-1:0] data_read_20;

    int n_checks = 0;
    int n_fail   = 0;

    dual_port_ram #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(32)) dut (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable),
        .address_write(address_write), .data_write(data_write),
        .address_read(address_read), .data_read(data_read)
    );

    dual_port_ram #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable),
        .address_write(address_write), .data_write(data_write),
        .address_read(address_read), .data_read(data_read_20)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write_enable = 1'b0; address_write = '0;
        data_write = '0; address_read = '0;
        #3;
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL reset_data_read: got %h expected 00", data_read);
        end
        cycle(); cycle();
        #3 rst_n = 1'b1;
        address_read = 5'h1B;
        cycle();
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL reset_read_1b: got %h expected 00", data_read);
        end
    endtask

    task automatic test_write_read();
        write_enable = 1'b1; address_write = 5'h1B; data_write = 8'hC5;
        cycle();
        write_enable = 1'b0; address_read = 5'h1B;
        cycle();
        n_checks++;
        if (data_read !== 8'hC5) begin
            n_fail++; $display("FAIL write_read_1b: got %h expected c5", data_read);
        end
        // Changing the address must not reach data_read before the next edge.
        address_read = 5'h1A;
        #2;
        n_checks++;
        if (data_read !== 8'hC5) begin
            n_fail++; $display("FAIL read_latency_hold: got %h expected c5", data_read);
        end
        cycle();
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL neighbour_1a: got %h expected 00", data_read);
        end
    endtask

    task automatic test_same_address();
        logic [DW-1:0] exp_same;
`ifdef RAM_WRITE_THROUGH_EN
        exp_same = 8'h3C;
`else
        exp_same = 8'h00;
`endif
        write_enable = 1'b1; address_write = 5'h05; data_write = 8'h3C;
        address_read = 5'h05;
        cycle();
        write_enable = 1'b0;
        n_checks++;
        if (data_read !== exp_same) begin
            n_fail++; $display("FAIL same_edge_rw: got %h expected %h", data_read, exp_same);
        end
        cycle();
        n_checks++;
        if (data_read !== 8'h3C) begin
            n_fail++; $display("FAIL same_edge_next_read: got %h expected 3c", data_read);
        end
    endtask

    task automatic test_boundaries();
        write_enable = 1'b1; address_write = 5'h00; data_write = 8'hAA;
        cycle();
        address_write = 5'h1F; data_write = 8'h55;
        cycle();
        write_enable = 1'b0; address_read = 5'h00;
        cycle();
        n_checks++;
        if (data_read !== 8'hAA) begin
            n_fail++; $display("FAIL boundary_low: got %h expected aa", data_read);
        end
        n_checks++;
        if (data_read_20 !== 8'hAA) begin
            n_fail++; $display("FAIL boundary_low_a20: got %h expected aa", data_read_20);
        end
        address_read = 5'h1F;
        cycle();
        n_checks++;
        if (data_read !== 8'h55) begin
            n_fail++; $display("FAIL boundary_high: got %h expected 55", data_read);
        end
        n_checks++;
        if (data_read_20 !== 8'h00) begin
            n_fail++; $display("FAIL boundary_high_a20: got %h expected 00", data_read_20);
        end
    endtask

    task automatic test_out_of_range();
        // Index 0x18 is valid for the 32-word instance and out of range for the 20-word one.
        logic [AW-1:0] addrs [5] = '{5'h18, 5'h04, 5'h08, 5'h00, 5'h05};
        logic [DW-1:0] exp20 [5] = '{8'h00, 8'h00, 8'h00, 8'hAA, 8'h3C};
        logic [DW-1:0] exp32 [5] = '{8'h77, 8'h00, 8'h00, 8'hAA, 8'h3C};
        write_enable = 1'b1; address_write = 5'h18; data_write = 8'h77;
        cycle();
        write_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            address_read = addrs[i];
            cycle();
            n_checks++;
            if (data_read_20 !== exp20[i]) begin
                n_fail++;
                $display("FAIL oor_a20_addr_%h: got %h expected %h", addrs[i], data_read_20, exp20[i]);
            end
            n_checks++;
            if (data_read !== exp32[i]) begin
                n_fail++;
                $display("FAIL oor_a32_addr_%h: got %h expected %h", addrs[i], data_read, exp32[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        write_enable = 1'b1; address_write = 5'h1B; data_write = 8'hC5;
        cycle();
        write_enable = 1'b0; address_read = 5'h1B;
        cycle();
        n_checks++;
        if (data_read !== 8'hC5) begin
            n_fail++; $display("FAIL pre_reset_1b: got %h expected c5", data_read);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL async_reset_immediate: got %h expected 00", data_read);
        end
        // Write attempted on an edge while reset is held.
        write_enable = 1'b1; address_write = 5'h03; data_write = 8'h99;
        address_read = 5'h1B;
        cycle();
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL reset_hold_read: got %h expected 00", data_read);
        end
        #3 rst_n = 1'b1;
        // First edge after release accepts a write.
        address_write = 5'h07; data_write = 8'h42; address_read = 5'h03;
        cycle();
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL reset_write_discarded: got %h expected 00", data_read);
        end
        write_enable = 1'b0; address_read = 5'h07;
        cycle();
        n_checks++;
        if (data_read !== 8'h42) begin
            n_fail++; $display("FAIL first_write_after_release: got %h expected 42", data_read);
        end
        address_read = 5'h1B;
        cycle();
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL post_reset_1b: got %h expected 00", data_read);
        end
        address_read = 5'h00;
        cycle();
        n_checks++;
        if (data_read !== 8'h00) begin
            n_fail++; $display("FAIL post_reset_00: got %h expected 00", data_read);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_address();
        test_boundaries();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
